// File: rtl/uart_rx_16x_pkg.sv
// Shared definitions for the 16x-oversampled UART receiver: FSM encodings,
// oversampling/baud constants and the 3-sample majority helper.
package uart_rx_16x_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } rx_state_e;

   localparam int OVS_DEFAULT   = 16;
   // 50 MHz / (9600 * 16), rounded; consumed by the tick generator
   localparam int BAUD_TICK_DIV = 326;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_16x_if.sv
// Byte delivery channel from the UART receiver to the command parser:
// valid/ready handshake plus the framing-error and overrun pulses.
interface uart_rx_16x_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 frame_err;
   logic                 overrun;

   modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ready);
   modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_rx_16x_sync_2ff.sv
// STAGES-deep flop synchroniser for an asynchronous input; resets to 1 so an
// idle-high line reads idle while the chain fills.
module sync_2ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver on a 16x baud-tick enable: majority-voted start/data/stop
// sampling, valid/ready byte delivery, framing-error and overrun pulses.
module uart_rx_16x
   import uart_rx_16x_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int OVS         = OVS_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk50MHz,
   input  logic            reset_n,
   input  logic            baud_tick,
   input  logic            rx_in,
   uart_rx_16x_if.master   rx_if
);

   localparam int CW = $clog2(OVS);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(OVS - 1);
   localparam logic [CW-1:0] START_S0  = CW'(OVS/2 - 3);
   localparam logic [CW-1:0] START_DEC = CW'(OVS/2 - 1);
   localparam logic [CW-1:0] BIT_S0    = CW'(OVS - 3);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

   logic rx_s;

   rx_state_e              state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic [1:0]             smp_q, smp_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
   logic                   ovr_q, ovr_d;
   logic                   armed_q, armed_d;
   logic [SYNC_STAGES-1:0] prime_q;

   logic [CW-1:0] samp_base;
   logic [CW-1:0] dec_cnt;
   logic          vote;
   logic          decide;
   logic          primed;

   sync_2ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk50MHz),
      .rst_n (reset_n),
      .d_i   (rx_in),
      .q_o   (rx_s)
   );

   // rx_s only reflects the real line once the synchroniser has refilled after
   // reset; a start is allowed only after that line has been seen high.
   assign primed  = prime_q[SYNC_STAGES-1];
   assign armed_d = armed_q | (primed & rx_s);

   assign samp_base = (state_q == START) ? START_S0  : BIT_S0;
   assign dec_cnt   = (state_q == START) ? START_DEC : CNT_LAST;
   assign vote      = maj3(smp_q[0], smp_q[1], rx_s);
   assign decide    = baud_tick && (cnt_q == dec_cnt);

   always_ff @(posedge clk50MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         smp_q   <= '1;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         armed_q <= 1'b0;
         prime_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         smp_q   <= smp_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
         armed_q <= armed_d;
         prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   always_comb begin
      state_d = state_q;
      if (baud_tick) begin
         case (state_q)
            IDLE:      if (!rx_s && armed_q) state_d = START;
            START:     if (decide) state_d = vote ? IDLE : DATA;
            DATA:      if (decide && idx_q == IDX_LAST) state_d = STOP;
            STOP:      if (decide) state_d = vote ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_d = IDLE;
            default:   state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      smp_d   = smp_q;
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;

      if (valid_q && rx_if.rx_ready) valid_d = 1'b0;

      if (baud_tick) begin
         if (cnt_q == samp_base)          smp_d[0] = rx_s;
         if (cnt_q == samp_base + CW'(1)) smp_d[1] = rx_s;
         case (state_q)
            START: cnt_d = decide ? '0 : cnt_q + CW'(1);
            DATA: begin
               cnt_d = cnt_q + CW'(1);
               if (decide) begin
                  shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                  idx_d   = idx_q + IW'(1);
               end
            end
            STOP: begin
               cnt_d = cnt_q + CW'(1);
               if (decide) begin
                  if (!vote) begin
                     ferr_d = 1'b1;
                  end else if (!valid_q || rx_if.rx_ready) begin
                     // a same-cycle accept frees the slot, so the load wins
                     data_d  = shreg_q;
                     valid_d = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
               end
            end
            default: begin
               cnt_d = '0;
               idx_d = '0;
            end
         endcase
      end
   end

   assign rx_if.rx_data   = data_q;
   assign rx_if.rx_valid  = valid_q;
   assign rx_if.frame_err = ferr_q;
   assign rx_if.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed bench for uart_rx_16x: serialises 8N1 frames against a free-running
// baud tick and checks delivered bytes, pulses and reset behaviour.
module tb_uart_rx_16x;

   logic clk50MHz  = 1'b0;
   logic reset_n   = 1'b1;
   logic baud_tick = 1'b0;
   logic rx_in     = 1'b1;

   uart_rx_16x_if #(.DATA_BITS(8)) rx_if ();

   uart_rx_16x #(.DATA_BITS(8), .OVS(16), .SYNC_STAGES(2)) dut (
      .clk50MHz  (clk50MHz),
      .reset_n   (reset_n),
      .baud_tick (baud_tick),
      .rx_in     (rx_in),
      .rx_if     (rx_if.master)
   );

   always #10 clk50MHz = ~clk50MHz;

   // Tick period scaled down from 326 clk to keep run time short; the line
   // bit period is set in clk independently so tick skew is real skew.
   int tick_div = 16;
   int bit_clk  = 16 * 16;
   int tick_ctr = 0;

   initial begin
      forever begin
         @(negedge clk50MHz);
         tick_ctr++;
         if (tick_ctr >= tick_div) begin
            baud_tick = 1'b1;
            tick_ctr  = 0;
         end else begin
            baud_tick = 1'b0;
         end
      end
   end

   int         vcyc, nacc, nferr, novr;
   logic [7:0] last_acc;

   always @(negedge clk50MHz) begin
      if (reset_n) begin
         if (rx_if.rx_valid) vcyc++;
         if (rx_if.rx_valid && rx_if.rx_ready) begin
            nacc++;
            last_acc = rx_if.rx_data;
         end
         if (rx_if.frame_err) nferr++;
         if (rx_if.overrun)   novr++;
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr_mon();
      vcyc = 0; nacc = 0; nferr = 0; novr = 0; last_acc = 8'h00;
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk50MHz);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx_in = b;
      wait_clk(bit_clk);
   endtask

   task automatic idle_bits(input int n);
      repeat (n) send_bit(1'b1);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   initial begin
      rx_if.rx_ready = 1'b0;
      clr_mon();
      #5 reset_n = 1'b0;
      wait_clk(4);
      chk("rst_valid", rx_if.rx_valid, 0);
      chk("rst_data", rx_if.rx_data, 0);
      chk("rst_ferr", rx_if.frame_err, 0);
      chk("rst_ovr", rx_if.overrun, 0);
      reset_n = 1'b1;
      wait_clk(4);
      idle_bits(2);

      // single byte, consumer always ready
      rx_if.rx_ready = 1'b1;
      clr_mon();
      send_frame(8'hA5, 1'b1);
      idle_bits(2);
      chk("a5_count", nacc, 1);
      chk("a5_data", last_acc, 8'hA5);
      chk("a5_vcyc", vcyc, 1);
      chk("a5_ferr", nferr, 0);
      chk("a5_ovr", novr, 0);

      // back-to-back with stalled consumer: second byte overruns
      rx_if.rx_ready = 1'b0;
      clr_mon();
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      idle_bits(1);
      chk("ovr_valid", rx_if.rx_valid, 1);
      chk("ovr_data", rx_if.rx_data, 8'h3C);
      chk("ovr_pulses", novr, 1);
      chk("ovr_acc0", nacc, 0);
      rx_if.rx_ready = 1'b1;
      wait_clk(2);
      chk("ovr_drop", rx_if.rx_valid, 0);
      idle_bits(1);
      chk("ovr_acc1", nacc, 1);
      chk("ovr_accdata", last_acc, 8'h3C);

      // stop bit low, then a long break, then a good byte
      clr_mon();
      send_frame(8'h55, 1'b0);
      repeat (40) send_bit(1'b0);
      chk("fe_pulses", nferr, 1);
      chk("fe_novalid", vcyc, 0);
      idle_bits(1);
      send_frame(8'h12, 1'b1);
      idle_bits(2);
      chk("brk_count", nacc, 1);
      chk("brk_data", last_acc, 8'h12);
      chk("brk_ferr", nferr, 1);

      // 4-tick low glitch is rejected; following byte held unaccepted
      clr_mon();
      rx_in = 1'b0;
      wait_clk(4 * tick_div);
      rx_in = 1'b1;
      idle_bits(2);
      chk("glitch_vcyc", vcyc, 0);
      chk("glitch_ferr", nferr, 0);
      rx_if.rx_ready = 1'b0;
      send_frame(8'hFF, 1'b1);
      idle_bits(1);
      chk("ff_valid", rx_if.rx_valid, 1);
      chk("ff_data", rx_if.rx_data, 8'hFF);

      // reset in the middle of data bit 3 of 0x81
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      rx_in = 1'b0;
      wait_clk(bit_clk / 2);
      reset_n = 1'b0;
      #2;
      chk("mid_rst_valid", rx_if.rx_valid, 0);
      chk("mid_rst_data", rx_if.rx_data, 0);
      wait_clk(3);
      reset_n = 1'b1;
      clr_mon();
      wait_clk(bit_clk / 2 - 3);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      idle_bits(2);
      chk("partial_vcyc", vcyc, 0);
      chk("partial_ferr", nferr, 0);
      rx_if.rx_ready = 1'b1;
      send_frame(8'h7E, 1'b1);
      idle_bits(2);
      chk("post_rst_count", nacc, 1);
      chk("post_rst_data", last_acc, 8'h7E);

      // +/-3% tick skew against a 33-clk nominal tick
      bit_clk  = 16 * 33;
      tick_div = 32;
      idle_bits(2);
      clr_mon();
      send_frame(8'h00, 1'b1);
      idle_bits(2);
      chk("fast_count", nacc, 1);
      chk("fast_data", last_acc, 8'h00);
      chk("fast_ferr", nferr, 0);
      tick_div = 34;
      idle_bits(2);
      clr_mon();
      send_frame(8'hFF, 1'b1);
      idle_bits(2);
      chk("slow_count", nacc, 1);
      chk("slow_data", last_acc, 8'hFF);
      chk("slow_ferr", nferr, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
